// File: rtl/time_chain_ctrl.sv
// Sequencing controller for the sec/min/hr/day counter chain: 1 Hz prescaler,
// button press detection, RUN cascade and one-field-at-a-time set mode.
module time_chain_ctrl #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       MODE_BTN,
    input  logic       INC_BTN,
    input  logic       SEC_TC,
    input  logic       MIN_TC,
    input  logic       HR_TC,
    output logic       SEC_EN,
    output logic       MIN_EN,
    output logic       HR_EN,
    output logic       DAY_EN,
    output logic       UP,
    output logic       SEC_LD,
    output logic [1:0] STATE,
    output logic       TICK
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    localparam logic [1:0] ST_RUN     = 2'b00;
    localparam logic [1:0] ST_SET_MIN = 2'b01;
    localparam logic [1:0] ST_SET_HR  = 2'b10;
    localparam logic [1:0] ST_SET_DAY = 2'b11;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic             clr_flag_q, clr_flag_d;
    logic             mode_prev_q, inc_prev_q;
    logic             mode_press, inc_press, inc_only;

    assign TICK       = (cnt_q == CNT_LAST);
    assign cnt_d      = TICK ? '0 : cnt_q + CNT_W'(1);
    assign mode_press = MODE_BTN & ~mode_prev_q;
    assign inc_press  = INC_BTN & ~inc_prev_q;
    // A MODE press in the same cycle swallows the INC press.
    assign inc_only   = inc_press & ~mode_press;
    assign state_d    = mode_press ? state_q + 2'd1 : state_q;
    assign clr_flag_d = mode_press & (state_q == ST_RUN);
    assign STATE      = state_q;

    // prev resets high so a button held through reset never yields a press.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            cnt_q       <= '0;
            state_q     <= ST_RUN;
            clr_flag_q  <= 1'b0;
            mode_prev_q <= 1'b1;
            inc_prev_q  <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            clr_flag_q  <= clr_flag_d;
            mode_prev_q <= MODE_BTN;
            inc_prev_q  <= INC_BTN;
        end
    end

    always_comb begin
        SEC_EN = 1'b0;
        MIN_EN = 1'b0;
        HR_EN  = 1'b0;
        DAY_EN = 1'b0;
        SEC_LD = clr_flag_q;
        case (state_q)
            ST_RUN: begin
                SEC_EN = TICK;
                MIN_EN = TICK & SEC_TC;
                HR_EN  = TICK & SEC_TC & MIN_TC;
                DAY_EN = TICK & SEC_TC & MIN_TC & HR_TC;
            end
            ST_SET_MIN: begin
                SEC_EN = clr_flag_q;
                MIN_EN = inc_only;
            end
            ST_SET_HR:  HR_EN  = inc_only;
            ST_SET_DAY: DAY_EN = inc_only;
            default: ;
        endcase
        UP = (SEC_EN | MIN_EN | HR_EN | DAY_EN) & ~SEC_LD;
    end

endmodule

// File: tb/tb_time_chain_ctrl.sv
// Bench for time_chain_ctrl: directed scenarios plus random buttons/TC/reset,
// compared every cycle against a cycle-count/mode-index reference model.
module tb_time_chain_ctrl;

    localparam int TD = 4;

    logic       Clk = 1'b0;
    logic       Clr = 1'b1;
    logic       MODE_BTN = 1'b0, INC_BTN = 1'b0;
    logic       SEC_TC = 1'b0, MIN_TC = 1'b0, HR_TC = 1'b0;
    logic       SEC_EN, MIN_EN, HR_EN, DAY_EN, UP, SEC_LD, TICK;
    logic [1:0] STATE;

    time_chain_ctrl #(.TICK_DIV(TD)) dut (
        .Clk(Clk), .Clr(Clr), .MODE_BTN(MODE_BTN), .INC_BTN(INC_BTN),
        .SEC_TC(SEC_TC), .MIN_TC(MIN_TC), .HR_TC(HR_TC),
        .SEC_EN(SEC_EN), .MIN_EN(MIN_EN), .HR_EN(HR_EN), .DAY_EN(DAY_EN),
        .UP(UP), .SEC_LD(SEC_LD), .STATE(STATE), .TICK(TICK)
    );

    always #5 Clk = ~Clk;

    int nchk = 0, nfail = 0;
    int age, mode_idx;
    bit clr_pending, m_prev, i_prev;
    int ld_cnt, min_cnt, en_cnt;
    logic last_tick;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nchk++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] obs_vec();
        return {STATE, TICK, SEC_EN, MIN_EN, HR_EN, DAY_EN, UP, SEC_LD};
    endfunction

    function automatic logic [8:0] model_vec();
        bit tick, mp, ip, s, m, h, d, ld, up;
        tick = !Clr && (age % TD) == TD - 1;
        mp = !Clr && MODE_BTN && !m_prev;
        ip = !Clr && INC_BTN && !i_prev;
        s = 0; m = 0; h = 0; d = 0;
        if (mode_idx == 0) begin
            s = tick;
            m = tick && SEC_TC;
            h = tick && SEC_TC && MIN_TC;
            d = tick && SEC_TC && MIN_TC && HR_TC;
        end else begin
            s = clr_pending;
            if (ip && !mp) begin
                if (mode_idx == 1) m = 1;
                if (mode_idx == 2) h = 1;
                if (mode_idx == 3) d = 1;
            end
        end
        ld = clr_pending;
        up = (s || m || h || d) && !ld;
        return {2'(mode_idx), tick, s, m, h, d, up, ld};
    endfunction

    task automatic model_reset();
        age = 0; mode_idx = 0; clr_pending = 0; m_prev = 1; i_prev = 1;
    endtask

    task automatic model_advance();
        bit mp;
        mp = MODE_BTN && !m_prev;
        age++;
        clr_pending = mp && mode_idx == 0;
        if (mp) mode_idx = (mode_idx + 1) % 4;
        m_prev = MODE_BTN;
        i_prev = INC_BTN;
    endtask

    // One clock: compare at the falling edge, step the model at the rising edge.
    task automatic cycle(input string tag);
        @(negedge Clk);
        chk(tag, 16'(obs_vec()), 16'(model_vec()));
        last_tick = TICK;
        if (SEC_LD) ld_cnt++;
        if (MIN_EN) min_cnt++;
        if (SEC_EN || MIN_EN || HR_EN || DAY_EN) en_cnt++;
        @(posedge Clk);
        if (Clr) model_reset(); else model_advance();
        #1;
    endtask

    task automatic cycles(input int n, input string tag);
        for (int k = 0; k < n; k++) cycle(tag);
    endtask

    task automatic mode_pulse(input int hold);
        MODE_BTN = 1; cycles(hold, "mode_hi");
        MODE_BTN = 0; cycles(3, "mode_lo");
    endtask

    initial begin
        model_reset();
        cycles(2, "in_rst");
        Clr = 0;
        // 1. Reset mid-RUN with TCs high, then first-tick timing.
        SEC_TC = 1; MIN_TC = 1; HR_TC = 1;
        cycles(6, "run_pre");
        #2 Clr = 1; model_reset();
        #1 chk("rst_imm", 16'(obs_vec()), 16'h0);
        cycles(2, "rst_hold");
        Clr = 0;
        for (int i = 1; i <= 12; i++) begin
            cycle("post_rst");
            chk("tick_cycle", 16'(last_tick), 16'((i % TD) == 0));
        end
        // 2. Cascade combinations.
        SEC_TC = 0; cycles(8, "casc_none");
        SEC_TC = 1; MIN_TC = 1; HR_TC = 1; en_cnt = 0; cycles(8, "casc_all");
        chk("casc_all_en_cycles", 16'(en_cnt), 16'd2);
        MIN_TC = 0; cycles(8, "casc_sec_min");
        // 3. Mode cycle.
        ld_cnt = 0;
        mode_pulse(3); chk("state1", 16'(STATE), 16'd1);
        mode_pulse(3); chk("state2", 16'(STATE), 16'd2);
        mode_pulse(3); chk("state3", 16'(STATE), 16'd3);
        mode_pulse(3); chk("state0", 16'(STATE), 16'd0);
        chk("sec_ld_cycles", 16'(ld_cnt), 16'd1);
        // 4. Set minutes: held INC, then ticks with TCs high.
        mode_pulse(3);
        MIN_TC = 1; min_cnt = 0;
        INC_BTN = 1; cycles(5, "set_min_inc");
        INC_BTN = 0;
        chk("min_en_cycles", 16'(min_cnt), 16'd1);
        en_cnt = 0; cycles(8, "set_min_tick");
        chk("set_min_no_en", 16'(en_cnt), 16'd0);
        // 5. Simultaneous press in SET_HR.
        mode_pulse(3); chk("state_sethr", 16'(STATE), 16'd2);
        en_cnt = 0;
        MODE_BTN = 1; INC_BTN = 1; cycles(2, "simul");
        chk("simul_state", 16'(STATE), 16'd3);
        chk("simul_no_en", 16'(en_cnt), 16'd0);
        MODE_BTN = 0; INC_BTN = 0; cycles(2, "simul_lo");
        // 6. MODE held through reset.
        MODE_BTN = 1;
        #2 Clr = 1; model_reset();
        cycles(2, "held_rst");
        Clr = 0;
        cycles(10, "held_after");
        chk("held_state", 16'(STATE), 16'd0);
        MODE_BTN = 0; cycles(2, "held_fall");
        MODE_BTN = 1; cycles(2, "held_rise");
        chk("held_repress", 16'(STATE), 16'd1);
        MODE_BTN = 0;
        // Random mix of buttons, TCs and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) MODE_BTN = ~MODE_BTN;
            if ($urandom_range(0, 2) == 0) INC_BTN = ~INC_BTN;
            {SEC_TC, MIN_TC, HR_TC} = 3'($urandom_range(0, 7));
            if (Clr) Clr = 0;
            else if ($urandom_range(0, 99) == 0) begin
                Clr = 1; model_reset();
            end
            cycle("rand");
        end
        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end

endmodule

// File: doc/time_chain_ctrl.md
# time_chain_ctrl

Controller that sequences the alarm-clock time-of-day counter chain: seconds (0-59), minutes (0-59), hours (0-23) and day-of-week (0-6). It generates the 1 Hz tick and drives the synchronous Enable/Up/LD inputs of each counter. It cascades carries in RUN mode and runs a button-driven set mode that advances one field at a time. It sits between the debounced front-panel buttons and the counter datapath.

## Interface

- TICK_DIV, default 50000000: Clk cycles per 1 Hz tick; must be ≥ 2.
- Clk  in  1  system clock; all state updates on rising edge.
- Clr  in  1  asynchronous, active-high reset.
- MODE_BTN  in  1  debounced, synchronized mode button (level); rising edge is a press.
- INC_BTN  in  1  debounced, synchronized increment button (level); rising edge is a press.
- SEC_TC  in  1  seconds counter is at 59.
- MIN_TC  in  1  minutes counter is at 59.
- HR_TC  in  1  hours counter is at 23.
- SEC_EN, MIN_EN, HR_EN, DAY_EN  out  1 each  Enable to each counter.
- UP  out  1  Up to all counters.
- SEC_LD  out  1  LD to seconds counter; its load inputs are tied to 0.
- STATE  out  2  00 RUN, 01 SET_MIN, 10 SET_HR, 11 SET_DAY.
- TICK  out  1  one-cycle 1 Hz pulse.

## Operation

- **Prescaler.** Counts 0..TICK_DIV-1 and wraps to 0. It is free-running in every state. TICK = 1 only when count == TICK_DIV-1.
- **Press detect.** Registered previous value per button. press = BTN & ~prev.
  - prev resets to 1, so a button held through reset gives no press.
  - A held button gives exactly one press.
- **FSM.** A MODE press moves RUN→SET_MIN→SET_HR→SET_DAY→RUN. No other transitions.
- **RUN:**
  - SEC_EN = TICK
  - MIN_EN = TICK & SEC_TC
  - HR_EN = TICK & SEC_TC & MIN_TC
  - DAY_EN = TICK & SEC_TC & MIN_TC & HR_TC
  - INC presses are ignored.
- **SET_MIN / SET_HR / SET_DAY:**
  - The selected field's EN = INC press (one cycle). All other ENs are 0.
  - TICK is ignored, so seconds are frozen.
  - There is no carry between fields: minutes 59→00 leaves hours unchanged, because the wrap happens inside the counter.
- **Seconds clear.** A registered flag is set on the RUN→SET_MIN transition and lasts one cycle. During that first cycle in SET_MIN: SEC_EN = 1, SEC_LD = 1, UP = 0, so seconds load 0.
- **UP** = 1 whenever any EN is 1 and SEC_LD = 0; otherwise UP = 0.
- **Simultaneous MODE and INC press in one cycle.** MODE wins: the state advances and all ENs stay 0 that cycle.
- **All outputs are combinational** from the registered state, the seconds-clear flag, the prescaler compare, the press terms and the TC inputs. No EN is ever asserted for more than one consecutive cycle, except SEC_EN when TICK_DIV = 1; that value is disallowed.
- **Reset (Clr high).** Takes effect immediately and holds while Clr is high:
  - STATE = 00, prescaler = 0, flag = 0, prev = 1.
  - All outputs 0: TICK, every EN, UP, SEC_LD.
- **Clr mid-set-mode.** Abandons set mode and returns to RUN. Counter contents are not this block's concern.

## Timing

- TICK first asserts in cycle TICK_DIV after Clr deasserts, then every TICK_DIV cycles.
- Button rises in cycle c, so press = 1 in cycle c:
  - INC: the selected EN is high in cycle c, and the counter updates at the edge ending cycle c. Zero cycles of latency.
  - MODE: STATE changes at the edge ending cycle c.
- Seconds clear: SEC_LD/SEC_EN are high in cycle c+1 after the MODE press in RUN, and seconds = 0 after edge c+1.
- A cascade is a single cycle: all involved ENs assert in the same TICK cycle, and all counters update on the same edge.

## Test plan

Use TICK_DIV = 4 for all scenarios.

1. **Reset.** Assert Clr mid-RUN with TC inputs = 1.
   - All outputs 0 and STATE = 00 immediately.
   - After release, the first TICK appears in cycle 4, then in cycles 8, 12, …
2. **Cascade.** In RUN:
   - SEC_TC = 0: only SEC_EN = UP = 1 in TICK cycles.
   - SEC_TC = MIN_TC = HR_TC = 1: SEC_EN, MIN_EN, HR_EN, DAY_EN and UP are all 1 for exactly the TICK cycle.
   - SEC_TC = 1, MIN_TC = 0: SEC_EN and MIN_EN only.
3. **Mode cycle.** Four MODE pulses, each held 3 cycles.
   - STATE goes 01, 10, 11, 00, changing once per pulse.
   - SEC_EN = SEC_LD = 1 with UP = 0 for exactly one cycle, after the first pulse only.
4. **Set minutes.** In SET_MIN, hold INC high for 5 cycles.
   - MIN_EN = UP = 1 for exactly one cycle.
   - TICK with all TC inputs = 1 gives zero ENs.
5. **Simultaneous press.** In SET_HR, MODE and INC rise in the same cycle.
   - STATE becomes 11.
   - HR_EN and DAY_EN stay 0 that cycle.
6. **Held through reset.** MODE_BTN held high across Clr release for 10 cycles.
   - STATE stays 00.
   - After the button falls and rises again, STATE = 01.
